bcd_time_decoder: RTL and testbench

Decodes a serial stream of BCD digits, entered most-significant first, into the packed binary time/date word that feeds the display path. Typical sources are keypad or set-button logic.
Collects six digits, converts each two-digit field from BCD to binary, and range-checks each field. A valid result is committed to time_date with a one-cycle load strobe; an invalid or aborted entry produces a one-cycle error strobe instead.

---
 rtl/bcd_time_decoder.sv | 248 ++++++++++++++++++++++++
 tb/tb_bcd_time_decoder.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_decoder.sv
// bcd_time_decoder: collects six serial BCD digits (MSB first), converts each
// two-digit field to binary, range-checks, and commits {f2,f1,f0} to time_date.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   digit_valid/digit digit offer (4-bit BCD)
//   digit_ready       combinational: digit accepted when digit_valid & digit_ready
//   clear             synchronous abort of the entry in progress (ignored in CHECK)
//   time_date         committed binary fields {f2,f1,f0}
//   load / error      one-cycle strobes: commit / rejection or timeout
//   busy              entry or conversion in progress
//   digit_idx         digits accepted so far (0..6)
module bcd_time_decoder #(
    parameter int unsigned FIELD2_MAX    = 23,
    parameter int unsigned FIELD1_MAX    = 59,
    parameter int unsigned FIELD0_MAX    = 59,
    parameter int unsigned ENTRY_TIMEOUT = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    output logic        digit_ready,
    input  logic        clear,
    output logic [23:0] time_date,
    output logic        load,
    output logic        error,
    output logic        busy,
    output logic [2:0]  digit_idx
);

    localparam int unsigned DIGITS  = 6;
    localparam int unsigned DIG_W   = 4;
    localparam int unsigned FIELD_W = 8;
    localparam int unsigned TD_W    = 3 * FIELD_W;
    localparam int unsigned BUF_W   = DIGITS * DIG_W;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CNV_W   = 2;
    localparam int unsigned TO_W    = (ENTRY_TIMEOUT > 1) ? $clog2(ENTRY_TIMEOUT) : 1;

    localparam logic            TO_EN   = (ENTRY_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((ENTRY_TIMEOUT == 0) ? 0 : ENTRY_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(DIGITS);
    localparam logic [CNV_W-1:0] LAST_CNV = CNV_W'(2);

    localparam logic [FIELD_W-1:0] F2_MAX = FIELD_W'(FIELD2_MAX);
    localparam logic [FIELD_W-1:0] F1_MAX = FIELD_W'(FIELD1_MAX);
    localparam logic [FIELD_W-1:0] F0_MAX = FIELD_W'(FIELD0_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CONVERT,
        ST_CHECK
    } state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   bcd_q, bcd_d;
    logic [TD_W-1:0]    stage_q, stage_d;
    logic [CNV_W-1:0]   cnv_idx_q, cnv_idx_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [TD_W-1:0]    time_date_d;
    logic               load_d, error_d, busy_d;
    logic [IDX_W-1:0]   digit_idx_d;

    logic               hs;
    logic               bad_digit;
    logic               fields_ok;
    logic [3:0]         cnv_tens, cnv_ones;
    logic [FIELD_W-1:0] cnv_bin;

    // Two-digit BCD to binary: tens*8 + tens*2 + ones, zero-extended.
    function automatic logic [FIELD_W-1:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
        logic [6:0] b;
        b = (7'(tens) << 3) + (7'(tens) << 1) + 7'(ones);
        return {1'b0, b};
    endfunction

    // Handshake is allowed only while collecting and not being aborted.
    assign digit_ready = ((state_q == ST_IDLE) || (state_q == ST_COLLECT)) && !clear;
    assign hs          = digit_valid && digit_ready;
    assign bad_digit   = (digit > 4'd9);

    // Field being converted this cycle: f2, f1, f0 in that order.
    always_comb begin
        cnv_tens = bcd_q[23:20];
        cnv_ones = bcd_q[19:16];
        case (cnv_idx_q)
            2'd0: begin
                cnv_tens = bcd_q[23:20];
                cnv_ones = bcd_q[19:16];
            end
            2'd1: begin
                cnv_tens = bcd_q[15:12];
                cnv_ones = bcd_q[11:8];
            end
            default: begin
                cnv_tens = bcd_q[7:4];
                cnv_ones = bcd_q[3:0];
            end
        endcase
        cnv_bin = bcd2bin(cnv_tens, cnv_ones);
    end

    assign fields_ok = (stage_q[23:16] <= F2_MAX) &&
                       (stage_q[15:8]  <= F1_MAX) &&
                       (stage_q[7:0]   <= F0_MAX);

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bcd_q     <= '0;
            stage_q   <= '0;
            cnv_idx_q <= '0;
            to_cnt_q  <= '0;
            time_date <= '0;
            load      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b0;
            digit_idx <= '0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            stage_q   <= stage_d;
            cnv_idx_q <= cnv_idx_d;
            to_cnt_q  <= to_cnt_d;
            time_date <= time_date_d;
            load      <= load_d;
            error     <= error_d;
            busy      <= busy_d;
            digit_idx <= digit_idx_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        bcd_d       = bcd_q;
        stage_d     = stage_q;
        cnv_idx_d   = cnv_idx_q;
        to_cnt_d    = to_cnt_q;
        time_date_d = time_date;
        digit_idx_d = digit_idx;
        load_d      = 1'b0;
        error_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    bcd_d       = '0;
                    digit_idx_d = '0;
                end else if (hs) begin
                    if (bad_digit) begin
                        error_d     = 1'b1;
                        bcd_d       = '0;
                        digit_idx_d = '0;
                    end else begin
                        bcd_d       = {20'd0, digit};
                        digit_idx_d = IDX_W'(1);
                        to_cnt_d    = '0;
                        state_d     = ST_COLLECT;
                    end
                end
            end

            ST_COLLECT: begin
                if (clear) begin
                    bcd_d       = '0;
                    digit_idx_d = '0;
                    to_cnt_d    = '0;
                    state_d     = ST_IDLE;
                end else if (hs) begin
                    to_cnt_d = '0;
                    if (bad_digit) begin
                        error_d     = 1'b1;
                        bcd_d       = '0;
                        digit_idx_d = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        // Shift in MSB-first so the first digit ends up as f2 tens.
                        bcd_d       = {bcd_q[BUF_W-DIG_W-1:0], digit};
                        digit_idx_d = digit_idx + IDX_W'(1);
                        if (digit_idx == LAST_IDX) begin
                            digit_idx_d = FULL_IDX;
                            cnv_idx_d   = '0;
                            state_d     = ST_CONVERT;
                        end
                    end
                end else if (TO_EN) begin
                    if (to_cnt_q == TO_LAST) begin
                        error_d     = 1'b1;
                        bcd_d       = '0;
                        digit_idx_d = '0;
                        to_cnt_d    = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end

            ST_CONVERT: begin
                if (clear) begin
                    bcd_d       = '0;
                    digit_idx_d = '0;
                    cnv_idx_d   = '0;
                    state_d     = ST_IDLE;
                end else begin
                    case (cnv_idx_q)
                        2'd0:    stage_d[23:16] = cnv_bin;
                        2'd1:    stage_d[15:8]  = cnv_bin;
                        default: stage_d[7:0]   = cnv_bin;
                    endcase
                    if (cnv_idx_q == LAST_CNV) begin
                        cnv_idx_d = '0;
                        state_d   = ST_CHECK;
                    end else begin
                        cnv_idx_d = cnv_idx_q + CNV_W'(1);
                    end
                end
            end

            ST_CHECK: begin
                // clear is deliberately ignored here: the check always completes.
                if (fields_ok) begin
                    time_date_d = stage_q;
                    load_d      = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
                bcd_d       = '0;
                digit_idx_d = '0;
                state_d     = ST_IDLE;
            end

            default: begin
                bcd_d       = '0;
                digit_idx_d = '0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_bcd_time_decoder.sv
// Bench for bcd_time_decoder: directed scenarios plus random traffic, all
// checked every cycle against a digit-queue model, with literal checkpoints.
module tb_bcd_time_decoder;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        clear = 1'b0;
    logic        digit_ready;
    logic [23:0] time_date;
    logic        load;
    logic        error;
    logic        busy;
    logic [2:0]  digit_idx;

    bcd_time_decoder #(
        .FIELD2_MAX(23),
        .FIELD1_MAX(59),
        .FIELD0_MAX(59),
        .ENTRY_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .digit_valid(digit_valid),
        .digit(digit),
        .digit_ready(digit_ready),
        .clear(clear),
        .time_date(time_date),
        .load(load),
        .error(error),
        .busy(busy),
        .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    // Model state: accepted digits, remaining busy cycles after the 6th digit,
    // idle cycle count, committed word and strobes expected after the next edge.
    int          m_digits[$];
    int          m_conv = 0;
    int          m_idle = 0;
    logic [23:0] m_td = '0;
    logic        m_load = 1'b0;
    logic        m_err = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int load_cyc = 0;
    int ld_since = 0;
    int er_since = 0;
    int ckpt = 0;
    int ack = 0;
    int stall_cnt = 0;

    task automatic lit(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic model_step();
        int f [3];
        m_load = 1'b0;
        m_err  = 1'b0;
        if (m_conv == 1) begin
            for (int i = 0; i < 3; i++) f[i] = 10 * m_digits[2*i] + m_digits[2*i+1];
            if (f[0] <= 23 && f[1] <= 59 && f[2] <= 59) begin
                m_td   = {8'(f[0]), 8'(f[1]), 8'(f[2])};
                m_load = 1'b1;
            end else begin
                m_err = 1'b1;
            end
            m_digits.delete();
            m_conv = 0;
        end else if (m_conv > 1) begin
            if (clear) begin
                m_digits.delete();
                m_conv = 0;
            end else begin
                m_conv--;
            end
        end else if (clear) begin
            m_digits.delete();
            m_idle = 0;
        end else if (digit_valid) begin
            m_idle = 0;
            if (digit > 4'd9) begin
                m_err = 1'b1;
                m_digits.delete();
            end else begin
                m_digits.push_back(int'(digit));
                if (m_digits.size() == 6) m_conv = 4;
            end
        end else if (m_digits.size() > 0) begin
            m_idle++;
            if (m_idle == int'(TO)) begin
                m_err = 1'b1;
                m_digits.delete();
                m_idle = 0;
            end
        end
    endtask

    // Compare process: check outputs, service checkpoints, then advance the model.
    always @(negedge clk) begin
        logic        e_ready, e_busy;
        logic [2:0]  e_idx;
        if (!rst_n) begin
            m_digits.delete();
            m_conv = 0;
            m_idle = 0;
            m_td   = '0;
            m_load = 1'b0;
            m_err  = 1'b0;
        end
        e_ready = (m_conv == 0) && !clear;
        e_busy  = (m_conv != 0) || (m_digits.size() != 0);
        e_idx   = 3'(m_digits.size());
        vectors++;
        if (time_date !== m_td || load !== m_load || error !== m_err || busy !== e_busy ||
            digit_idx !== e_idx || digit_ready !== e_ready) begin
            miscompares++;
            $display("FAIL cycle %0d: got td=%h ld=%b er=%b bz=%b idx=%0d rdy=%b, expected td=%h ld=%b er=%b bz=%b idx=%0d rdy=%b",
                     cyc, time_date, load, error, busy, digit_idx, digit_ready,
                     m_td, m_load, m_err, e_busy, e_idx, e_ready);
        end

        if (rst_n && digit_valid && digit_ready) hs_cyc = cyc;
        if (load) begin
            load_cyc = cyc;
            ld_since++;
        end
        if (error) er_since++;

        if (ckpt != ack) begin
            case (ckpt)
                1: begin
                    lit("reset_td", int'(time_date), 0);
                    lit("reset_idx", int'(digit_idx), 0);
                    lit("reset_busy", int'(busy), 0);
                    lit("reset_strobes", ld_since + er_since, 0);
                end
                2: begin
                    lit("e123456_td", int'(time_date), 24'h0C2238);
                    lit("e123456_loads", ld_since, 1);
                    lit("e123456_errs", er_since, 0);
                    lit("e123456_latency", load_cyc - hs_cyc, 5);
                end
                3: begin
                    lit("e235959_td", int'(time_date), 24'h173B3B);
                    lit("e235959_loads", ld_since, 1);
                end
                4: begin
                    lit("e240000_td", int'(time_date), 24'h173B3B);
                    lit("e240000_errs", er_since, 1);
                    lit("e240000_loads", ld_since, 0);
                end
                5: begin
                    lit("e006000_errs", er_since, 1);
                    lit("e006000_loads", ld_since, 0);
                end
                6: begin
                    lit("illegal_errs", er_since, 1);
                    lit("illegal_idx", int'(digit_idx), 0);
                    lit("illegal_busy", int'(busy), 0);
                end
                7: begin
                    lit("e000001_td", int'(time_date), 24'h000001);
                    lit("e000001_loads", ld_since, 1);
                end
                8: begin
                    lit("timeout_errs", er_since, 1);
                    lit("timeout_idx", int'(digit_idx), 0);
                end
                9: begin
                    lit("no_timeout_errs", er_since, 0);
                    lit("no_timeout_idx", int'(digit_idx), 3);
                end
                10: begin
                    lit("e123000_td", int'(time_date), 24'h0C1E00);
                    lit("e123000_loads", ld_since, 1);
                end
                11: begin
                    lit("clear_hs_idx", int'(digit_idx), 0);
                    lit("clear_hs_strobes", ld_since + er_since, 0);
                end
                12: begin
                    lit("clear_convert_td", int'(time_date), 24'h0C1E00);
                    lit("clear_convert_strobes", ld_since + er_since, 0);
                end
                13: begin
                    lit("clear_check_td", int'(time_date), 24'h010203);
                    lit("clear_check_loads", ld_since, 1);
                end
                14: begin
                    lit("midreset_td", int'(time_date), 0);
                    lit("midreset_idx", int'(digit_idx), 0);
                    lit("midreset_busy", int'(busy), 0);
                    lit("midreset_strobes", int'(load) + int'(error), 0);
                end
                15: begin
                    lit("e214530_td", int'(time_date), 24'h152D1E);
                    lit("e214530_loads", ld_since, 1);
                end
                default: lit("stimulus_stalls", stall_cnt, 0);
            endcase
            ld_since = 0;
            er_since = 0;
            ack = ckpt;
        end

        cyc++;
        if (rst_n) model_step();
    end

    task automatic do_ckpt(input int k);
        ckpt = k;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (ack == k) break;
        end
        if (ack != k) stall_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Offer one digit and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [3:0] d);
        logic got;
        got = 1'b0;
        digit = d;
        digit_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (digit_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) stall_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic entry6(input logic [23:0] ds);
        for (int i = 5; i >= 0; i--) send(ds[4*i +: 4]);
        digit_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (!busy && !load && !error) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) stall_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_ckpt(1);

        entry6(24'h123456);
        wait_idle();
        do_ckpt(2);

        entry6(24'h235959);
        wait_idle();
        do_ckpt(3);
        entry6(24'h240000);
        wait_idle();
        do_ckpt(4);
        entry6(24'h006000);
        wait_idle();
        do_ckpt(5);

        send(4'd1);
        send(4'd2);
        send(4'hA);
        digit_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_ckpt(6);
        entry6(24'h000001);
        wait_idle();
        do_ckpt(7);

        send(4'd1);
        send(4'd2);
        digit_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;
        do_ckpt(8);

        send(4'd1);
        send(4'd2);
        digit_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        send(4'd3);
        digit_valid = 1'b0;
        do_ckpt(9);
        send(4'd0);
        send(4'd0);
        send(4'd0);
        digit_valid = 1'b0;
        wait_idle();
        do_ckpt(10);

        send(4'd1);
        send(4'd2);
        send(4'd3);
        clear = 1'b1;
        digit = 4'd4;
        digit_valid = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        digit_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_ckpt(11);

        entry6(24'h010203);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        wait_idle();
        do_ckpt(12);

        entry6(24'h010203);
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        wait_idle();
        do_ckpt(13);

        send(4'd1);
        send(4'd2);
        send(4'd3);
        digit_valid = 1'b0;
        rst_n = 1'b0;
        do_ckpt(14);
        rst_n = 1'b1;
        entry6(24'h214530);
        wait_idle();
        do_ckpt(15);

        for (int c = 0; c < 1500; c++) begin
            int r;
            if ($urandom_range(0, 99) < 3) begin
                digit_valid = 1'b0;
                clear = 1'b0;
                repeat (20) @(posedge clk);
                #1;
            end else begin
                clear = ($urandom_range(0, 99) < 4);
                digit_valid = ($urandom_range(0, 99) < 70);
                r = int'($urandom_range(0, 99));
                if (r < 5)
                    digit = 4'($urandom_range(10, 15));
                else if (m_digits.size() == 0)
                    digit = 4'($urandom_range(0, 2));
                else if ((m_digits.size() % 2) == 0)
                    digit = 4'($urandom_range(0, 5));
                else
                    digit = 4'($urandom_range(0, 9));
                @(posedge clk);
                #1;
            end
        end
        digit_valid = 1'b0;
        clear = 1'b0;
        wait_idle();
        do_ckpt(99);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
